dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, data-memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data word width (four byte lanes).
REQ-003 SHALL have parameter MAXBURST, default 16, maximum host burst length in beats.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock, all state on posedge.
REQ-005 rstd  input  1  asynchronous active-low reset.
REQ-006 cpu_req  input  1  CPU load/store request, held until granted.
REQ-007 cpu_wren  input  4  CPU byte-lane write enables, active-low (1111 = read).
REQ-008 cpu_addr  input  AW  CPU word address.
REQ-009 cpu_wdata  input  DW  CPU store data.
REQ-010 cpu_gnt  output  1  CPU access performed this cycle.
REQ-011 cpu_stall  output  1  equals cpu_req & ~cpu_gnt.
REQ-012 cpu_rdata  output  DW  load data, valid when cpu_gnt.
REQ-013 host_req  input  1  host burst request, held for the whole burst.
REQ-014 host_wr  input  1  1 = burst write, 0 = burst read; sampled at burst start.
REQ-015 host_addr  input  AW  burst start address; sampled at burst start.
REQ-016 host_len  input  4  beats, 0 encodes 16; sampled at burst start.
REQ-017 host_wdata  input  DW  write data for the current beat.
REQ-018 host_ack  output  1  one beat transferred this cycle.
REQ-019 host_rdata  output  DW  read data, valid when host_ack and ~host_wr.
REQ-020 busy  output  1  high while a host burst is in progress.
REQ-021 mem_addr  output  AW, mem_wren output 4 (active-low), mem_wdata output DW, mem_rdata input DW  port to the four byte-lane data memories (combinational read, write on posedge).

Function
REQ-022 SHALL implement states IDLE and HOST; no CPU state (CPU accesses complete in one cycle).
REQ-023 In IDLE, if only cpu_req: cpu_gnt=1 combinationally, memory driven from CPU port, state stays IDLE, last=CPU.
REQ-024 In IDLE, if only host_req: no access this cycle; latch addr/len/wr, load beat counter, go to HOST.
REQ-025 In IDLE with both requests: grant the requester not equal to last; last resets to HOST so CPU wins the first tie.
REQ-026 In HOST each cycle with host_req=1: one beat at mem_addr = base + beat index (modulo 2^AW wrap), host_ack=1; writes use mem_wren=0000 and host_wdata; reads return mem_rdata on host_rdata.
REQ-027 After the final beat (counter reaches len) SHALL return to IDLE next edge with last=HOST; busy falls with it.
REQ-028 host_req low in HOST SHALL abort: no access that cycle, host_ack=0, return to IDLE next edge.
REQ-029 cpu_gnt SHALL be 0 throughout HOST; maximum CPU wait = MAXBURST+1 cycles.
REQ-030 When no access is performed, mem_wren SHALL be 1111 and mem_addr/mem_wdata are don't-care.
REQ-031 host_wr, host_addr, host_len changes during HOST SHALL be ignored.

Reset
REQ-032 rstd low SHALL immediately force state IDLE, counter 0, last=HOST, busy=0, host_ack=0, cpu_gnt=0, mem_wren=1111.
REQ-033 Reset mid-burst SHALL abort without any further memory write; first post-reset cycle behaves as IDLE.

Structure
REQ-034 Package dmem_arb_pkg SHALL hold the state encoding, AW/DW/MAXBURST defaults and the active-low write encodings WREN_NONE=1111, WREN_WORD=0000.
REQ-035 The beat counter with len-0-as-16 decode and done flag SHALL be sub-module dmem_burst_ctr.

Verification
REQ-036 CPU store cpu_addr=0x10, wren=1100, wdata=0xAABBCCDD, no host -> cpu_gnt same cycle, mem lanes 0,1 become DD,CC; following load returns 0x????CCDD.
REQ-037 Host write burst addr=0xFE, len=3, data 1,2,3 -> host_ack three consecutive cycles, words 0xFE,0xFF,0x00 = 1,2,3 (wrap), busy high 3 cycles.
REQ-038 cpu_req and host_req asserted together after reset -> CPU granted first; next cycle host burst starts; after burst, new tie -> CPU granted.
REQ-039 host_len=0 read burst while cpu_req held -> 16 acks, cpu_stall high 17 cycles, cpu_gnt on cycle 18.
REQ-040 rstd pulsed low after 2 beats of a len=8 write -> outputs at reset values immediately, only 2 words modified.
REQ-041 host_req dropped after beat 4 of len=8 -> host_ack low that cycle, IDLE next edge, pending CPU request granted.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encodings, parameter
// defaults and the active-low byte-lane write encodings.
package dmem_arb_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 32;
  localparam int MAXBURST_DEF = 16;

  localparam logic [3:0] WREN_NONE = 4'b1111;
  localparam logic [3:0] WREN_WORD = 4'b0000;

  typedef enum logic {
    ST_IDLE,
    ST_HOST
  } state_e;

  typedef enum logic {
    LAST_CPU,
    LAST_HOST
  } owner_e;

  // A 4-bit burst length of zero stands for the maximum burst of 16 beats.
  function automatic logic [4:0] decode_len(input logic [3:0] len);
    return (len == 4'd0) ? 5'd16 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Beat counter for host bursts: captures the decoded length at burst start and
// flags the final beat.
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [3:0]    len_i,
  output logic [CW-1:0] idx_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (load_i) begin
      cnt_d = '0;
      len_d = CW'(decode_len(len_i));
    end else if (step_i) begin
      cnt_d = done_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign idx_o  = cnt_q;
  assign done_o = ((cnt_q + CW'(1)) == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-cycle CPU load/store port against a host burst port for
// one shared byte-lane data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_wren,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [3:0]    host_len,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAXBURST + 1);

  state_e        state_q;
  owner_e        last_q;
  logic [AW-1:0] base_q;
  logic          wr_q;
  logic          busy_q;

  logic          cpuWin;
  logic          hostStart;
  logic          hostBeat;
  logic [CW-1:0] beatIdx;
  logic          beatDone;

  // Grants are gated by rstd so every access strobe drops the moment reset asserts.
  assign cpuWin    = rstd & (state_q == ST_IDLE) & cpu_req &
                     (~host_req | (last_q == LAST_HOST));
  assign hostStart = rstd & (state_q == ST_IDLE) & host_req & ~cpuWin;
  assign hostBeat  = rstd & (state_q == ST_HOST) & host_req;

  dmem_burst_ctr #(.CW(CW)) u_ctr (
    .clk    (clk),
    .rstd   (rstd),
    .load_i (hostStart),
    .step_i (hostBeat),
    .len_i  (host_len),
    .idx_o  (beatIdx),
    .done_o (beatDone)
  );

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = WREN_NONE;
    if (hostBeat) begin
      mem_addr  = base_q + AW'(beatIdx);
      mem_wdata = host_wdata;
      mem_wren  = wr_q ? WREN_WORD : WREN_NONE;
    end else if (cpuWin) begin
      mem_wren = cpu_wren;
    end
  end

  // Burst attributes are captured only at burst start; a dropped host_req aborts.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_HOST;
      base_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpuWin) begin
            last_q <= LAST_CPU;
          end else if (hostStart) begin
            state_q <= ST_HOST;
            base_q  <= host_addr;
            wr_q    <= host_wr;
            busy_q  <= 1'b1;
          end
        end
        ST_HOST: begin
          if (!host_req || beatDone) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_HOST;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = cpuWin;
  assign cpu_stall  = cpu_req & ~cpuWin;
  assign cpu_rdata  = mem_rdata;
  assign host_ack   = hostBeat;
  assign host_rdata = mem_rdata;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected accesses, a
// negedge monitor retires them whenever the DUT grants or acknowledges.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstd;
  logic          cpuReq;
  logic [3:0]    cpuWren;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWdata;
  logic          cpuGnt;
  logic          cpuStall;
  logic [DW-1:0] cpuRdata;
  logic          hostReq;
  logic          hostWr;
  logic [AW-1:0] hostAddr;
  logic [3:0]    hostLen;
  logic [DW-1:0] hostWdata;
  logic          hostAck;
  logic [DW-1:0] hostRdata;
  logic          busy;
  logic [AW-1:0] memAddr;
  logic [3:0]    memWren;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;

  logic [DW-1:0] mem [256];
  logic          memReady = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  wren;
    logic        chkRd;
    logic [31:0] data;
  } exp_t;

  exp_t cpuQ[$];
  exp_t hostQ[$];
  exp_t cpuE;
  exp_t hostE;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAXBURST(16)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .cpu_req    (cpuReq),
    .cpu_wren   (cpuWren),
    .cpu_addr   (cpuAddr),
    .cpu_wdata  (cpuWdata),
    .cpu_gnt    (cpuGnt),
    .cpu_stall  (cpuStall),
    .cpu_rdata  (cpuRdata),
    .host_req   (hostReq),
    .host_wr    (hostWr),
    .host_addr  (hostAddr),
    .host_len   (hostLen),
    .host_wdata (hostWdata),
    .host_ack   (hostAck),
    .host_rdata (hostRdata),
    .busy       (busy),
    .mem_addr   (memAddr),
    .mem_wren   (memWren),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata)
  );

  // Every word starts as its address replicated in all four byte lanes.
  assign memRdata = mem[memAddr];

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}};
      memReady <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (!memWren[b]) mem[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
    end
  end

  function automatic exp_t mkExp(input logic [7:0] a, input logic [3:0] w,
                                 input logic c, input logic [31:0] d);
    exp_t e;
    e.addr  = a;
    e.wren  = w;
    e.chkRd = c;
    e.data  = d;
    return e;
  endfunction

  function automatic logic [31:0] pat(input int a);
    return {4{8'(a)}};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [3:0] wren,
                               input logic [7:0] addr, input logic [31:0] wdata);
    cpuReq   = req;
    cpuWren  = wren;
    cpuAddr  = addr;
    cpuWdata = wdata;
  endtask

  task automatic hostDrive(input logic req, input logic wr, input logic [7:0] addr,
                           input logic [3:0] len, input logic [31:0] wdata);
    hostReq   = req;
    hostWr    = wr;
    hostAddr  = addr;
    hostLen   = len;
    hostWdata = wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor retires queued expectations on each grant/ack and checks the idle bus.
  always @(negedge clk) begin
    if (rstd === 1'b1) begin
      if (cpuGnt === 1'b1) begin
        if (cpuQ.size() == 0) begin
          checkOutput("cpu_gnt unexpected", 32'(cpuGnt), 32'd0);
        end else begin
          cpuE = cpuQ.pop_front();
          checkOutput("cpu mem_addr", 32'(memAddr), 32'(cpuE.addr));
          checkOutput("cpu mem_wren", 32'(memWren), 32'(cpuE.wren));
          if (cpuE.chkRd) checkOutput("cpu_rdata", cpuRdata, cpuE.data);
          else            checkOutput("cpu mem_wdata", memWdata, cpuE.data);
        end
      end
      if (hostAck === 1'b1) begin
        if (hostQ.size() == 0) begin
          checkOutput("host_ack unexpected", 32'(hostAck), 32'd0);
        end else begin
          hostE = hostQ.pop_front();
          checkOutput("host mem_addr", 32'(memAddr), 32'(hostE.addr));
          checkOutput("host mem_wren", 32'(memWren), 32'(hostE.wren));
          if (hostE.chkRd) checkOutput("host_rdata", hostRdata, hostE.data);
          else             checkOutput("host mem_wdata", memWdata, hostE.data);
        end
      end
      if (cpuGnt !== 1'b1 && hostAck !== 1'b1)
        checkOutput("no-access mem_wren", 32'(memWren), 32'hF);
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int stallCnt;
    int gntCycle;
    int ackCnt;

    rstd = 1'b1;
    applyStimulus(1'b1, 4'hF, 8'h05, 32'h0);
    hostDrive(1'b0, 1'b0, 8'h00, 4'd0, 32'h0);
    #2 rstd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cpu_gnt", 32'(cpuGnt), 32'd0);
    checkOutput("reset host_ack", 32'(hostAck), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mem_wren", 32'(memWren), 32'hF);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    rstd = 1'b1;

    // CPU partial store then load back.
    cpuQ.push_back(mkExp(8'h10, 4'b1100, 1'b0, 32'hAABBCCDD));
    applyStimulus(1'b1, 4'b1100, 8'h10, 32'hAABBCCDD);
    @(negedge clk);
    checkOutput("store cpu_gnt", 32'(cpuGnt), 32'd1);
    checkOutput("store cpu_stall", 32'(cpuStall), 32'd0);
    step();
    cpuQ.push_back(mkExp(8'h10, 4'hF, 1'b1, 32'h1010CCDD));
    applyStimulus(1'b1, 4'hF, 8'h10, 32'h0);
    @(negedge clk);
    checkOutput("load cpu_gnt", 32'(cpuGnt), 32'd1);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);

    // Host write burst wrapping past the top of memory.
    hostQ.push_back(mkExp(8'hFE, 4'h0, 1'b0, 32'd1));
    hostQ.push_back(mkExp(8'hFF, 4'h0, 1'b0, 32'd2));
    hostQ.push_back(mkExp(8'h00, 4'h0, 1'b0, 32'd3));
    hostDrive(1'b1, 1'b1, 8'hFE, 4'd3, 32'h0);
    @(negedge clk);
    checkOutput("wr latch host_ack", 32'(hostAck), 32'd0);
    checkOutput("wr latch busy", 32'(busy), 32'd0);
    step();
    for (int b = 0; b < 3; b++) begin
      hostDrive(1'b1, 1'b0, 8'h33, 4'd9, 32'(b + 1));
      @(negedge clk);
      checkOutput("wr beat host_ack", 32'(hostAck), 32'd1);
      checkOutput("wr beat busy", 32'(busy), 32'd1);
      step();
    end
    hostDrive(1'b0, 1'b0, 8'h00, 4'd0, 32'h0);
    @(negedge clk);
    checkOutput("wr done busy", 32'(busy), 32'd0);
    checkOutput("mem[FE]", mem[8'hFE], 32'd1);
    checkOutput("mem[FF]", mem[8'hFF], 32'd2);
    checkOutput("mem[00]", mem[8'h00], 32'd3);
    step();

    // Fresh reset so last=HOST, then tie: CPU first, host burst, tie again.
    rstd = 1'b0;
    step();
    rstd = 1'b1;
    cpuQ.push_back(mkExp(8'h20, 4'hF, 1'b1, 32'h20202020));
    hostQ.push_back(mkExp(8'h30, 4'hF, 1'b1, 32'h30303030));
    hostQ.push_back(mkExp(8'h31, 4'hF, 1'b1, 32'h31313131));
    applyStimulus(1'b1, 4'hF, 8'h20, 32'h0);
    hostDrive(1'b1, 1'b0, 8'h30, 4'd2, 32'h0);
    @(negedge clk);
    checkOutput("tie1 cpu_gnt", 32'(cpuGnt), 32'd1);
    checkOutput("tie1 host_ack", 32'(hostAck), 32'd0);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("tie1 host latch busy", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    checkOutput("tie1 beat0 host_ack", 32'(hostAck), 32'd1);
    step();
    cpuQ.push_back(mkExp(8'h21, 4'hF, 1'b1, 32'h21212121));
    applyStimulus(1'b1, 4'hF, 8'h21, 32'h0);
    @(negedge clk);
    checkOutput("tie1 beat1 host_ack", 32'(hostAck), 32'd1);
    checkOutput("tie1 beat1 cpu_gnt", 32'(cpuGnt), 32'd0);
    checkOutput("tie1 beat1 cpu_stall", 32'(cpuStall), 32'd1);
    step();
    @(negedge clk);
    checkOutput("tie2 cpu_gnt", 32'(cpuGnt), 32'd1);
    checkOutput("tie2 host_ack", 32'(hostAck), 32'd0);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    hostDrive(1'b0, 1'b0, 8'h00, 4'd0, 32'h0);

    // last=CPU now, so the host wins this tie with a 16-beat read.
    cpuQ.push_back(mkExp(8'h40, 4'hF, 1'b1, 32'h40404040));
    for (int i = 0; i < 16; i++)
      hostQ.push_back(mkExp(8'(8'h50 + i), 4'hF, 1'b1, pat(8'h50 + i)));
    applyStimulus(1'b1, 4'hF, 8'h40, 32'h0);
    hostDrive(1'b1, 1'b0, 8'h50, 4'd0, 32'h0);
    stallCnt = 0;
    gntCycle = 0;
    ackCnt   = 0;
    for (int c = 1; c <= 40 && gntCycle == 0; c++) begin
      @(negedge clk);
      if (hostAck === 1'b1) ackCnt++;
      if (cpuGnt === 1'b1) gntCycle = c;
      else if (cpuStall === 1'b1) stallCnt++;
      step();
    end
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    hostDrive(1'b0, 1'b0, 8'h00, 4'd0, 32'h0);
    checkOutput("len16 ack count", 32'(ackCnt), 32'd16);
    checkOutput("len16 stall cycles", 32'(stallCnt), 32'd17);
    checkOutput("len16 gnt cycle", 32'(gntCycle), 32'd18);

    // Reset in the middle of a write burst after two beats.
    hostQ.push_back(mkExp(8'h60, 4'h0, 1'b0, 32'hA0));
    hostQ.push_back(mkExp(8'h61, 4'h0, 1'b0, 32'hA1));
    hostDrive(1'b1, 1'b1, 8'h60, 4'd8, 32'h0);
    step();
    for (int b = 0; b < 2; b++) begin
      hostDrive(1'b1, 1'b1, 8'h60, 4'd8, 32'(32'hA0 + b));
      @(negedge clk);
      checkOutput("rst burst host_ack", 32'(hostAck), 32'd1);
      step();
    end
    hostDrive(1'b1, 1'b1, 8'h60, 4'd8, 32'hA2);
    applyStimulus(1'b1, 4'hF, 8'h61, 32'h0);
    rstd = 1'b0;
    #1;
    checkOutput("midrst host_ack", 32'(hostAck), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst mem_wren", 32'(memWren), 32'hF);
    checkOutput("midrst cpu_gnt", 32'(cpuGnt), 32'd0);
    step();
    hostDrive(1'b0, 1'b0, 8'h00, 4'd0, 32'h0);
    cpuQ.push_back(mkExp(8'h61, 4'hF, 1'b1, 32'h000000A1));
    rstd = 1'b1;
    @(negedge clk);
    checkOutput("post-reset cpu_gnt", 32'(cpuGnt), 32'd1);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    for (int i = 0; i < 8; i++)
      checkOutput("midrst mem word", mem[8'h60 + i],
                  (i < 2) ? 32'(32'hA0 + i) : pat(8'h60 + i));

    // Host drops its request after four beats while the CPU waits.
    for (int b = 0; b < 4; b++)
      hostQ.push_back(mkExp(8'(8'h70 + b), 4'h0, 1'b0, 32'(32'hB0 + b)));
    cpuQ.push_back(mkExp(8'h73, 4'hF, 1'b1, 32'h000000B3));
    hostDrive(1'b1, 1'b1, 8'h70, 4'd8, 32'h0);
    step();
    for (int b = 0; b < 4; b++) begin
      hostDrive(1'b1, 1'b1, 8'h70, 4'd8, 32'(32'hB0 + b));
      if (b == 0) applyStimulus(1'b1, 4'hF, 8'h73, 32'h0);
      @(negedge clk);
      checkOutput("abort beat host_ack", 32'(hostAck), 32'd1);
      step();
    end
    hostDrive(1'b0, 1'b1, 8'h70, 4'd8, 32'hB4);
    @(negedge clk);
    checkOutput("abort host_ack", 32'(hostAck), 32'd0);
    checkOutput("abort cpu_gnt", 32'(cpuGnt), 32'd0);
    checkOutput("abort mem_wren", 32'(memWren), 32'hF);
    checkOutput("abort busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    checkOutput("after abort cpu_gnt", 32'(cpuGnt), 32'd1);
    checkOutput("after abort busy", 32'(busy), 32'd0);
    step();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0);
    checkOutput("abort mem[74]", mem[8'h74], 32'h74747474);

    repeat (2) step();
    checkOutput("cpu queue drained", 32'(cpuQ.size()), 32'd0);
    checkOutput("host queue drained", 32'(hostQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
